// File: rtl/uart_regbank_n.sv
// uart_regbank_n: CPU register window for NUM_CH UART channels plus a global interrupt block.
// Latency: writes land at the access edge, read data and rd_valid appear one cycle after re.
// No backpressure: one access per cycle, strobes are combinational; UART_REGBANK_WLOCK_EN adds the LOCK register.
module uart_regbank_n #(
  parameter int                NUM_CH       = 6,
  parameter int                ADDR_W       = 22,
  parameter int                CH_STRIDE    = 5,
  parameter logic [ADDR_W-1:0] GLB_BASE     = 'h0100,
  parameter logic [31:0]       CR_RST_VAL   = 32'h0000C000,
  parameter logic [31:0]       TTR_RST_VAL  = 32'h00000004,
  parameter int                CR_RXRST_BIT = 1,
  parameter int                CR_TXRST_BIT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   we,
  input  logic                   re,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   rd_valid,
  input  logic [32*NUM_CH-1:0]   sr_i,
  input  logic [32*NUM_CH-1:0]   rdr_i,
  input  logic [NUM_CH-1:0]      ch_evt,
  output logic [32*NUM_CH-1:0]   cr_o,
  output logic [32*NUM_CH-1:0]   ttr_o,
  output logic [32*NUM_CH-1:0]   tdr_o,
  output logic [NUM_CH-1:0]      tx_write,
  output logic [NUM_CH-1:0]      sr_read,
  output logic [NUM_CH-1:0]      rx_read,
  output logic                   irq
);

  localparam int OFF_CR  = 0;
  localparam int OFF_TTR = 1;
  localparam int OFF_SR  = 2;
  localparam int OFF_TDR = 3;
  localparam int OFF_RDR = 4;

  localparam logic [31:0] INFO_VAL = {16'h0, 8'h02, 8'(NUM_CH)};

  logic [31:0]       cr  [NUM_CH];
  logic [31:0]       ttr [NUM_CH];
  logic [31:0]       tdr [NUM_CH];
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] mask;

  logic [NUM_CH-1:0] hit_cr, hit_ttr, hit_sr, hit_tdr, hit_rdr;
  logic              hit_pend, hit_mask, hit_info;
  logic              wr_ok;
  logic [31:0]       rd_mux;
  logic [NUM_CH-1:0] w1c;

`ifdef UART_REGBANK_WLOCK_EN
  logic locked;
  logic hit_lock;
  assign hit_lock = (addr == GLB_BASE + ADDR_W'(3));
  assign wr_ok    = ~locked;

  // Lock register: only the key value opens the bank, anything else closes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      locked <= 1'b1;
    end else if (we && hit_lock) begin
      locked <= (write_data != 32'hA5A50001);
    end
  end
`else
  assign wr_ok = 1'b1;
`endif

  // Address decode: one compare per channel register plus the global block
  always_comb begin
    hit_cr  = '0;
    hit_ttr = '0;
    hit_sr  = '0;
    hit_tdr = '0;
    hit_rdr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      hit_cr[c]  = (addr == ADDR_W'(c * CH_STRIDE + OFF_CR));
      hit_ttr[c] = (addr == ADDR_W'(c * CH_STRIDE + OFF_TTR));
      hit_sr[c]  = (addr == ADDR_W'(c * CH_STRIDE + OFF_SR));
      hit_tdr[c] = (addr == ADDR_W'(c * CH_STRIDE + OFF_TDR));
      hit_rdr[c] = (addr == ADDR_W'(c * CH_STRIDE + OFF_RDR));
    end
    hit_pend = (addr == GLB_BASE);
    hit_mask = (addr == GLB_BASE + ADDR_W'(1));
    hit_info = (addr == GLB_BASE + ADDR_W'(2));
  end

  // Channel strobes follow the access cycle directly and are suppressed in reset
  assign tx_write = (we && rst_n) ? hit_tdr : '0;
  assign sr_read  = (re && rst_n) ? hit_sr  : '0;
  assign rx_read  = (re && rst_n) ? hit_rdr : '0;

  // Read mux over current register contents (pre-write value on simultaneous we/re)
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (hit_cr[c])  rd_mux = cr[c];
      if (hit_ttr[c]) rd_mux = ttr[c];
      if (hit_sr[c])  rd_mux = sr_i[32*c +: 32];
      if (hit_tdr[c]) rd_mux = tdr[c];
      if (hit_rdr[c]) rd_mux = rdr_i[32*c +: 32];
    end
    if (hit_pend) rd_mux = 32'(pend);
    if (hit_mask) rd_mux = 32'(mask);
    if (hit_info) rd_mux = INFO_VAL;
`ifdef UART_REGBANK_WLOCK_EN
    if (hit_lock) rd_mux = {31'h0, locked};
`endif
  end

  // Per-channel control registers; FIFO reset bits drop one cycle after being written
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cr[c]  <= CR_RST_VAL;
        ttr[c] <= TTR_RST_VAL;
        tdr[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        cr[c][CR_RXRST_BIT] <= 1'b0;
        cr[c][CR_TXRST_BIT] <= 1'b0;
        if (we && hit_cr[c] && wr_ok)  cr[c]  <= write_data;
        if (we && hit_ttr[c] && wr_ok) ttr[c] <= write_data;
        if (we && hit_tdr[c])          tdr[c] <= write_data;
      end
    end
  end

  assign w1c = (we && hit_pend) ? write_data[NUM_CH-1:0] : '0;

  // Interrupt pending/mask; a new event outranks a same-cycle W1C
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend <= '0;
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      pend <= (pend & ~w1c) | ch_evt;
      if (we && hit_mask && wr_ok) mask <= write_data[NUM_CH-1:0];
      irq  <= |(pend & mask);
    end
  end

  // Registered read return; data holds between reads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_data <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= re;
      if (re) read_data <= rd_mux;
    end
  end

  // Flatten register arrays onto the output buses
  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign cr_o[32*g +: 32]  = cr[g];
    assign ttr_o[32*g +: 32] = ttr[g];
    assign tdr_o[32*g +: 32] = tdr[g];
  end

endmodule

// File: tb/tb_uart_regbank_n.sv
// Testbench for uart_regbank_n: random CPU accesses checked against a register-map model.
// Model keeps registers as arrays and decodes addresses with plain division.
module tb_uart_regbank_n;

  localparam int          NUM_CH = 6;
  localparam int          ADDR_W = 22;
  localparam logic [21:0] GLB    = 22'h0100;
  localparam logic [31:0] KEY    = 32'hA5A50001;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [ADDR_W-1:0]    addr;
  logic                 we, re;
  logic [31:0]          write_data;
  logic [31:0]          read_data;
  logic                 rd_valid;
  logic [32*NUM_CH-1:0] sr_i, rdr_i;
  logic [NUM_CH-1:0]    ch_evt;
  logic [32*NUM_CH-1:0] cr_o, ttr_o, tdr_o;
  logic [NUM_CH-1:0]    tx_write, sr_read, rx_read;
  logic                 irq;

  always #5 clk = ~clk;

  uart_regbank_n #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .we(we), .re(re),
    .write_data(write_data), .read_data(read_data), .rd_valid(rd_valid),
    .sr_i(sr_i), .rdr_i(rdr_i), .ch_evt(ch_evt),
    .cr_o(cr_o), .ttr_o(ttr_o), .tdr_o(tdr_o),
    .tx_write(tx_write), .sr_read(sr_read), .rx_read(rx_read), .irq(irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [31:0]       m_cr  [NUM_CH];
  logic [31:0]       m_ttr [NUM_CH];
  logic [31:0]       m_tdr [NUM_CH];
  logic [31:0]       m_sr  [NUM_CH];
  logic [31:0]       m_rdr [NUM_CH];
  logic [NUM_CH-1:0] m_pend, m_mask;
  logic              m_locked;
  logic [31:0]       m_rd_last;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit lock_feature();
`ifdef UART_REGBANK_WLOCK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [21:0] a);
    int ai = int'(a);
    if (ai < NUM_CH * 5) begin
      case (ai % 5)
        0: return m_cr[ai / 5];
        1: return m_ttr[ai / 5];
        2: return m_sr[ai / 5];
        3: return m_tdr[ai / 5];
        default: return m_rdr[ai / 5];
      endcase
    end
    if (a == GLB)     return 32'(m_pend);
    if (a == GLB + 1) return 32'(m_mask);
    if (a == GLB + 2) return 32'h0000_0200 + NUM_CH;
    if (a == GLB + 3 && lock_feature()) return {31'h0, m_locked};
    return 32'h0;
  endfunction

  task automatic check_regs(input string tag);
    logic [32*NUM_CH-1:0] ec, et, ed;
    for (int c = 0; c < NUM_CH; c++) begin
      ec[32*c +: 32] = m_cr[c];
      et[32*c +: 32] = m_ttr[c];
      ed[32*c +: 32] = m_tdr[c];
    end
    check({tag, ".cr_o"},  cr_o,  ec);
    check({tag, ".ttr_o"}, ttr_o, et);
    check({tag, ".tdr_o"}, tdr_o, ed);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_cr[c]  = 32'h0000C000;
      m_ttr[c] = 32'h00000004;
      m_tdr[c] = 32'h0;
    end
    m_pend = '0; m_mask = '0; m_locked = 1'b1; m_rd_last = '0;
  endtask

  task automatic drive_status();
    for (int c = 0; c < NUM_CH; c++) begin
      m_sr[c]  = $urandom;
      m_rdr[c] = $urandom;
      sr_i[32*c +: 32]  = m_sr[c];
      rdr_i[32*c +: 32] = m_rdr[c];
    end
  endtask

  // Reset with an access in flight: the access must vanish
  task automatic do_reset();
    rst_n = 1'b0; we = 1'b1; re = 1'b1; addr = 22'h3; write_data = $urandom; ch_evt = '1;
    drive_status();
    #1;
    check("rst.strobes", {tx_write, sr_read, rx_read}, '0);
    @(posedge clk); #1;
    model_reset();
    check("rst.rd_valid", rd_valid, 1'b0);
    check("rst.read_data", read_data, 32'h0);
    check("rst.irq", irq, 1'b0);
    check_regs("rst");
    rst_n = 1'b1; we = 1'b0; re = 1'b0; ch_evt = '0;
  endtask

  // One bus cycle: drive, check strobes, clock, update model, check outputs
  task automatic step(input logic w, input logic r, input logic [21:0] a,
                      input logic [31:0] d, input logic [NUM_CH-1:0] ev);
    logic [NUM_CH-1:0] etx, esr, erx;
    logic [31:0] exp_rd;
    logic exp_irq, ok;
    int ai, c, o;
    we = w; re = r; addr = a; write_data = d; ch_evt = ev;
    drive_status();
    #1;
    ai = int'(a);
    etx = '0; esr = '0; erx = '0;
    c = -1; o = -1;
    if (ai < NUM_CH * 5) begin
      c = ai / 5; o = ai % 5;
      etx[c] = w && (o == 3);
      esr[c] = r && (o == 2);
      erx[c] = r && (o == 4);
    end
    check("tx_write", tx_write, etx);
    check("sr_read",  sr_read,  esr);
    check("rx_read",  rx_read,  erx);

    exp_rd  = r ? m_read(a) : m_rd_last;
    exp_irq = |(m_pend & m_mask);
    ok      = !(lock_feature() && m_locked);

    for (int k = 0; k < NUM_CH; k++) m_cr[k][2:1] = 2'b00;
    if (w && c >= 0) begin
      if (o == 0 && ok) m_cr[c]  = d;
      if (o == 1 && ok) m_ttr[c] = d;
      if (o == 3)       m_tdr[c] = d;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (ev[k]) m_pend[k] = 1'b1;
      else if (w && a == GLB && d[k]) m_pend[k] = 1'b0;
    end
    if (w && a == GLB + 1 && ok) m_mask = d[NUM_CH-1:0];
    if (w && a == GLB + 3) m_locked = (d != KEY);

    @(posedge clk); #1;
    check("rd_valid", rd_valid, r);
    check("read_data", read_data, exp_rd);
    check("irq", irq, exp_irq);
    check_regs("step");
    m_rd_last = exp_rd;
  endtask

  initial begin
    logic [21:0] a;
    logic [31:0] d;
    int sel;
    rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = '0; write_data = '0; ch_evt = '0;
    sr_i = '0; rdr_i = '0;
    model_reset();
    do_reset();

    // Reset values through the bus
    step(0, 1, 22'h000A, 0, 0);
    check("cr2_reset", read_data, 32'h0000C000);
    step(0, 1, 22'h001A, 0, 0);
    check("ttr5_reset", read_data, 32'h00000004);

    if (lock_feature()) begin
      step(1, 0, 22'h0005, 32'h1234, 0);
      step(0, 1, 22'h0005, 0, 0);
      check("cr1_locked", read_data, 32'h0000C000);
      step(1, 0, GLB + 3, KEY, 0);
      step(1, 0, 22'h0005, 32'h1234, 0);
      step(0, 1, 22'h0005, 0, 0);
      check("cr1_unlocked", read_data, 32'h00001234);
    end

    // TDR write and its strobe
    step(1, 0, 22'h0012, 32'h55, 0);
    check("tdr3", tdr_o[127:96], 32'h55);
    step(0, 0, 0, 0, 0);
    check("tx_write_idle", tx_write, '0);

    // Self-clearing FIFO reset bits
    step(1, 0, 22'h0000, 32'h0000C006, 0);
    check("cr0_pulse", cr_o[2:1], 2'b11);
    step(0, 0, 0, 0, 0);
    check("cr0_cleared", cr_o[31:0], 32'h0000C000);

    // Interrupt set, set-beats-clear, W1C
    step(1, 0, GLB + 1, 32'h3F, 0);
    step(0, 0, 0, 0, 6'h10);
    step(0, 0, 0, 0, 0);
    check("irq_set", irq, 1'b1);
    step(1, 0, GLB, 32'h10, 6'h10);
    step(0, 1, GLB, 0, 0);
    check("pend_kept", read_data, 32'h10);
    step(1, 0, GLB, 32'h10, 0);
    step(0, 0, 0, 0, 0);
    check("irq_cleared", irq, 1'b0);

    // Simultaneous write and read, undecoded read, INFO
    step(1, 1, 22'h0006, 32'h9, 0);
    check("ttr1_prewrite", read_data, 32'h4);
    step(0, 1, 22'h0006, 0, 0);
    check("ttr1_new", read_data, 32'h9);
    step(1, 1, 22'h0200, 32'hFFFF_FFFF, 0);
    check("undecoded", read_data, 32'h0);
    step(0, 1, GLB + 2, 0, 0);
    check("info", read_data, 32'h00000206);

    // Mid-run reset
    do_reset();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)       a = 22'($urandom_range(0, NUM_CH * 5 - 1));
      else if (sel < 8)  a = GLB + 22'($urandom_range(0, 4));
      else if (sel == 8) a = 22'($urandom_range(0, 22'h3FFFFF));
      else               a = 22'h0200;
      d = $urandom;
      if (a == GLB + 3 && $urandom_range(0, 1) == 1) d = KEY;
      if ($urandom_range(0, 149) == 0) do_reset();
      else step(1'($urandom), 1'($urandom), a, d,
                ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_regbank_n.md
Name: uart_regbank_n

Overview:
- Parametrised successor to the fixed six-UART CPU register file.
- Decodes the CPU local-bus register window for NUM_CH identical UART channels at a fixed address stride, plus a global interrupt block.
- Holds per-channel CR/TTR/TDR, self-clears the CR FIFO reset bits, and generates per-channel access strobes.
- Returns read data one registered cycle later, with a valid flag; aggregates channel events into a maskable, write-1-to-clear interrupt.

Parameters:
- NUM_CH, 6: number of UART channels, 1..16.
- ADDR_W, 22: CPU word-address width.
- CH_STRIDE, 5: words per channel. Offsets: +0 CR, +1 TTR, +2 SR, +3 TDR, +4 RDR.
- GLB_BASE, 22'h0100: global block base. Offsets: +0 IRQ_PEND, +1 IRQ_MASK, +2 INFO, +3 LOCK.
- CR_RST_VAL, 32'h0000C000: CR reset value.
- TTR_RST_VAL, 32'h00000004: TTR reset value (4-character timeout).
- CR_RXRST_BIT, 1: CR bit index of rx FIFO reset.
- CR_TXRST_BIT, 2: CR bit index of tx FIFO reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- addr  in  ADDR_W  word address.
- we  in  1  write strobe, one cycle per access.
- re  in  1  read strobe, one cycle per access.
- write_data  in  32  write data.
- read_data  out  32  registered read data.
- rd_valid  out  1  read_data valid pulse.
- sr_i  in  32*NUM_CH  channel status words, channel c at [32c+31:32c].
- rdr_i  in  32*NUM_CH  channel receive data.
- ch_evt  in  NUM_CH  per-channel interrupt event pulses.
- cr_o  out  32*NUM_CH  CR registers.
- ttr_o  out  32*NUM_CH  TTR registers.
- tdr_o  out  32*NUM_CH  TDR registers.
- tx_write  out  NUM_CH  TDR write strobe.
- sr_read  out  NUM_CH  SR read strobe.
- rx_read  out  NUM_CH  RDR read strobe.
- irq  out  1  registered interrupt request.

Behaviour:
- Decode
  - Channel c occupies addr CH_STRIDE*c .. CH_STRIDE*c+4.
  - Addresses outside all channels and the global block are undecoded: writes ignored, reads return 0.
- Reset (rst_n=0 at posedge clk)
  - cr = CR_RST_VAL, ttr = TTR_RST_VAL, tdr = 0.
  - IRQ_PEND = 0, IRQ_MASK = 0.
  - read_data = 0, rd_valid = 0, irq = 0.
  - Reset mid-access discards the access; no rd_valid.
- Strobes
  - tx_write[c] = we & addr==TDR(c); sr_read[c] / rx_read[c] = re & addr==SR(c) / RDR(c).
  - Combinational, same cycle as the access.
  - Masked by rst_n=0.
- Writes
  - Take effect at the posedge where we=1.
  - SR/RDR/INFO writes are ignored.
  - IRQ_MASK[NUM_CH-1:0] is writable; upper bits read 0.
- Self-clearing CR bits
  - A write setting CR_RXRST_BIT or CR_TXRST_BIT holds that bit high for exactly one cycle, then hardware clears it.
  - A new CPU write in the clearing cycle wins; the written value is loaded.
- Reads
  - re at cycle N gives read_data and rd_valid=1 at cycle N+1. rd_valid=0 otherwise; read_data holds its last value.
  - Back-to-back reads supported, one per cycle.
  - INFO = {16'h0, 8'h02 (version), 8'(NUM_CH)}.
- Simultaneous we and re
  - Both are performed.
  - Read returns the pre-write value.
- Interrupts
  - ch_evt[c]=1 sets IRQ_PEND[c].
  - Writing 1 to an IRQ_PEND bit clears it; writing 0 leaves it.
  - Set and clear in the same cycle: set wins.
  - irq registered: irq(N+1) = |(IRQ_PEND(N) & IRQ_MASK(N)).

Optional Feature:
- Macro UART_REGBANK_WLOCK_EN.
- Defined:
  - LOCK register at GLB_BASE+3; reset value locked, reads 32'h1 when locked, 32'h0 when unlocked.
  - Writing 32'hA5A50001 unlocks; any other written value locks.
  - While locked, CR/TTR/IRQ_MASK writes are ignored. TDR writes, IRQ_PEND W1C and tx_write still work.
- Not defined:
  - GLB_BASE+3 is undecoded (reads 0).
  - CR/TTR/IRQ_MASK are always writable.

Test Plan:
- Reset, then read CR(2) (addr 22'h000A) -> rd_valid one cycle later, read_data=32'h0000C000; TTR(5) (22'h001A) returns 32'h00000004.
- Write TDR(3) (22'h0012) = 32'h55 -> tx_write=6'b001000 in the write cycle only; tdr_o[127:96]=32'h55 the next cycle.
- Write CR(0) = 32'h0000C006 -> cr_o[2:1]=2'b11 for one cycle, then cr_o[31:0]=32'h0000C000.
- IRQ_MASK=6'h3F, pulse ch_evt[4] -> irq=1; write IRQ_PEND=32'h10 in the same cycle as another ch_evt[4] -> bit stays set; W1C alone -> irq=0 one cycle later.
- Simultaneous we/re to TTR(1)=32'h9 -> read_data=32'h4; next read returns 32'h9. Read 22'h0200 -> 0.
- WLOCK_EN defined: write CR(1) while locked -> unchanged; write LOCK=32'hA5A50001, then CR(1)=32'h1234 -> reads 32'h1234.
